io_output_bank: RTL and testbench
=================================

// Module: io_output_bank
// ---------------------------------------------------------------------------
// PURPOSE
//  Parametrised MMIO output register bank for LED/HEX/LCD-class peripherals on the LSU I/O path.
//  NUM_CH 32-bit channels, SB/SH/SW masked stores, set/clear/toggle alias modes.
//  Optional shadow (double-buffered) update with a global commit strobe; 1-cycle registered readback.
// PARAMETERS
//  NUM_CH       8            number of 32-bit output channels (1..64)
//  PAGE         4'h7         i_io_addr[15:12] value that selects this bank
//  SHADOW_EN    1'b0         1: stores hit shadow regs, live outputs update on i_commit
//  BLANK_MASK   'h0C         bit k=1: channel k resets to 32'h7F7F_7F7F (HEX blank), else 0
// PORTS
//  i_clk        in   1              clock, all state on rising edge
//  i_reset      in   1              synchronous reset, active-low
//  i_io_addr    in   32             I/O byte address
//  i_st_data    in   32             store data (LSB-justified, as from rs2)
//  i_funct3     in   3              000 SB, 001 SH, 010 SW; others illegal
//  f_io_wren    in   1              store strobe, one cycle per store
//  i_rd_en      in   1              read strobe
//  i_commit     in   1              shadow->live copy strobe (ignored if SHADOW_EN=0)
//  o_rd_data    out  32             readback data
//  o_rd_valid   out  1              o_rd_data valid this cycle
//  o_err        out  1              one-cycle pulse: previous store was dropped
//  o_ch         out  NUM_CH*32      live channel values, channel k at [32k+31:32k]
// BEHAVIOUR
//  Reset (i_reset=0 at posedge): live+shadow ch k = BLANK_MASK[k] ? 32'h7F7F_7F7F : 0;
//    o_rd_data=0, o_rd_valid=0, o_err=0. Reset mid-store/read/commit: operation dropped.
//  Decode: hit = i_io_addr[15:12]==PAGE; mode = i_io_addr[11:10]; idx = i_io_addr[9:2].
//    mode 00 WRITE  r = (r & ~M) | (D & M)
//    mode 01 SET    r = r | (D & M)
//    mode 10 CLEAR  r = r & ~(D & M)
//    mode 11 TOGGLE r = r ^ (D & M)
//  M/D by funct3 and addr[1:0]: SB -> byte lane addr[1:0], D = st_data[7:0] replicated to all lanes;
//    SH -> lane pair addr[1], D = st_data[15:0] replicated; SW -> M=FFFF_FFFF, D=st_data.
//  Dropped stores (no reg change, o_err=1 next cycle): hit && (idx>=NUM_CH || illegal funct3
//    || SH with addr[0]=1 || SW with addr[1:0]!=0). Non-hit stores: ignored, no o_err.
//  Store latency: target reg updated at the posedge sampling f_io_wren; SHADOW_EN=0 -> o_ch
//    reflects it the following cycle; SHADOW_EN=1 -> shadow only, o_ch unchanged until commit.
//  Commit: i_commit=1 at posedge -> every live reg loads its shadow's next value, so a store in
//    the same cycle is included. Commit with no pending change is harmless.
//  Read: i_rd_en=1 with hit -> next cycle o_rd_valid=1, o_rd_data = full 32-bit shadow (live if
//    SHADOW_EN=0) value of idx as it was before any same-cycle store (read-before-write).
//    Non-hit or idx>=NUM_CH read: o_rd_valid=1, o_rd_data=0. No read: o_rd_valid=0, data holds.
//  Read and store same cycle, same or different channel: both performed.
//  No FSM stalls; accepts one store and one read every cycle; no backpressure.
// TESTING
//  Reset: release i_reset -> ch0=0, ch2=ch3=7F7F_7F7F (BLANK_MASK 'h0C), o_err=0.
//  SB 0xAB to 0x1000_7005 (ch1 lane1) over 0 -> ch1=0000_AB00; SH 0x1234 @..7006 -> 1234_AB00.
//  SET 0x0F @0x1000_7400 then CLEAR 0x03 @0x1000_7800 then TOGGLE 0xFF @0x1000_7C00 -> ch0=F3.
//  SH @0x1000_7001, SW @0x1000_7002, funct3=011, idx=NUM_CH -> each: no change, o_err pulse.
//  SHADOW_EN=1: SW 0x55 ch4, o_ch[4] still 0, readback 0x55; SW 0x66 ch4 + i_commit same cycle -> o_ch[4]=0x66.
//  Read ch1 with same-cycle SW 0x99 to ch1 -> o_rd_data=old value, next read returns 0x99.

Source files
------------

// File: rtl/io_output_bank_if.sv
// ---------------------------------------------------------------------------
// io_output_bank_if
//  LSU-side MMIO bus for the output register bank: store/read strobes,
//  address, store data, commit strobe and the registered read/err returns.
// ---------------------------------------------------------------------------
interface io_output_bank_if;
  logic [31:0] i_io_addr;
  logic [31:0] i_st_data;
  logic [2:0]  i_funct3;
  logic        f_io_wren;
  logic        i_rd_en;
  logic        i_commit;
  logic [31:0] o_rd_data;
  logic        o_rd_valid;
  logic        o_err;

  modport master (
    output i_io_addr, i_st_data, i_funct3, f_io_wren, i_rd_en, i_commit,
    input  o_rd_data, o_rd_valid, o_err
  );

  modport slave (
    input  i_io_addr, i_st_data, i_funct3, f_io_wren, i_rd_en, i_commit,
    output o_rd_data, o_rd_valid, o_err
  );
endinterface

// File: rtl/io_output_bank.sv
// ---------------------------------------------------------------------------
// io_output_bank
//  MMIO output register bank (LED/HEX/LCD class). NUM_CH 32-bit channels
//  written with SB/SH/SW masked stores in WRITE/SET/CLEAR/TOGGLE alias modes.
//  With SHADOW_EN the stores land in shadow registers and the live outputs
//  pick them up on i_commit. Readback is registered, one cycle after i_rd_en,
//  and returns the store target (shadow, or live when there is no shadow).
// ---------------------------------------------------------------------------
module io_output_bank #(
  parameter int          NUM_CH     = 8,
  parameter logic [3:0]  PAGE       = 4'h7,
  parameter bit          SHADOW_EN  = 1'b0,
  parameter logic [63:0] BLANK_MASK = 64'h0C
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  io_output_bank_if.slave        bus,
  output logic [NUM_CH*32-1:0]   o_ch
);

  localparam logic [8:0] NUM_CH_W = 9'(NUM_CH);

  // Reset value of channel k: HEX-blank pattern or zero.
  function automatic logic [31:0] blank_val(input int k);
    blank_val = BLANK_MASK[k] ? 32'h7F7F_7F7F : 32'h0000_0000;
  endfunction

  // Alias-mode read-modify-write of one register with mask m and data d.
  function automatic logic [31:0] apply_op(input logic [1:0]  mode,
                                           input logic [31:0] r,
                                           input logic [31:0] d,
                                           input logic [31:0] m);
    logic [31:0] dm;
    dm = d & m;
    case (mode)
      2'b00:   apply_op = (r & ~m) | dm;
      2'b01:   apply_op = r | dm;
      2'b10:   apply_op = r & ~dm;
      2'b11:   apply_op = r ^ dm;
      default: apply_op = r;
    endcase
  endfunction

  // Store target registers: shadow copy when SHADOW_EN, otherwise the live copy.
  logic [31:0] tgt_r     [NUM_CH];
  logic [31:0] tgt_nxt_s [NUM_CH];
  logic [31:0] live_s    [NUM_CH];

  logic        hit_s;
  logic [1:0]  mode_s;
  logic [7:0]  idx_s;
  logic        idx_ok_s;
  logic [31:0] mask_s;
  logic [31:0] data_s;
  logic        legal_s;
  logic        store_ok_s;
  logic        drop_s;
  logic [31:0] rd_word_s;

  assign hit_s    = (bus.i_io_addr[15:12] == PAGE);
  assign mode_s   = bus.i_io_addr[11:10];
  assign idx_s    = bus.i_io_addr[9:2];
  assign idx_ok_s = ({1'b0, idx_s} < NUM_CH_W);

  // Lane mask, replicated data and alignment legality from funct3 and addr[1:0].
  always_comb begin
    mask_s  = 32'h0000_0000;
    data_s  = 32'h0000_0000;
    legal_s = 1'b0;
    case (bus.i_funct3)
      3'b000: begin
        mask_s  = 32'h0000_00FF << {bus.i_io_addr[1:0], 3'b000};
        data_s  = {4{bus.i_st_data[7:0]}};
        legal_s = 1'b1;
      end
      3'b001: begin
        mask_s  = bus.i_io_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        data_s  = {2{bus.i_st_data[15:0]}};
        legal_s = ~bus.i_io_addr[0];
      end
      3'b010: begin
        mask_s  = 32'hFFFF_FFFF;
        data_s  = bus.i_st_data;
        legal_s = (bus.i_io_addr[1:0] == 2'b00);
      end
      default: begin
        mask_s  = 32'h0000_0000;
        data_s  = 32'h0000_0000;
        legal_s = 1'b0;
      end
    endcase
  end

  assign store_ok_s = bus.f_io_wren & hit_s & legal_s & idx_ok_s;
  assign drop_s     = bus.f_io_wren & hit_s & ~(legal_s & idx_ok_s);

  // Next value of every store target, applying an accepted store to its channel.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      tgt_nxt_s[k] = tgt_r[k];
      if (store_ok_s && (idx_s == 8'(k))) begin
        tgt_nxt_s[k] = apply_op(mode_s, tgt_r[k], data_s, mask_s);
      end else begin
        tgt_nxt_s[k] = tgt_r[k];
      end
    end
  end

  // Pre-store value of the addressed channel, so a same-cycle store is not seen.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    for (int k = 0; k < NUM_CH; k++) begin
      rd_word_s = (idx_s == 8'(k)) ? tgt_r[k] : rd_word_s;
    end
  end

  // Store target register array with per-channel blank reset values.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int k = 0; k < NUM_CH; k++) tgt_r[k] <= blank_val(k);
    end else begin
      for (int k = 0; k < NUM_CH; k++) tgt_r[k] <= tgt_nxt_s[k];
    end
  end

  generate
    if (SHADOW_EN) begin : g_shadow
      logic [31:0] live_r [NUM_CH];

      // Live registers load the shadow's next value on commit (includes same-cycle store).
      always_ff @(posedge i_clk) begin
        if (!i_reset) begin
          for (int k = 0; k < NUM_CH; k++) live_r[k] <= blank_val(k);
        end else if (bus.i_commit) begin
          for (int k = 0; k < NUM_CH; k++) live_r[k] <= tgt_nxt_s[k];
        end else begin
          for (int k = 0; k < NUM_CH; k++) live_r[k] <= live_r[k];
        end
      end

      assign live_s = live_r;
    end else begin : g_direct
      assign live_s = tgt_r;
    end
  endgenerate

  // Flatten live channels onto the output bus, channel k at [32k+31:32k].
  genvar gk;
  generate
    for (gk = 0; gk < NUM_CH; gk++) begin : g_och
      assign o_ch[32*gk +: 32] = live_s[gk];
    end
  endgenerate

  // Registered readback and dropped-store error pulse.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      bus.o_rd_data  <= 32'h0000_0000;
      bus.o_rd_valid <= 1'b0;
      bus.o_err      <= 1'b0;
    end else begin
      bus.o_err      <= drop_s;
      bus.o_rd_valid <= bus.i_rd_en;
      if (bus.i_rd_en) begin
        bus.o_rd_data <= (hit_s && idx_ok_s) ? rd_word_s : 32'h0000_0000;
      end else begin
        bus.o_rd_data <= bus.o_rd_data;
      end
    end
  end

  // Upper address bits are decoded upstream; commit is unused without a shadow.
  logic unused_s;
  assign unused_s = ^{bus.i_io_addr[31:16], bus.i_commit};

endmodule

// File: tb/tb_io_output_bank.sv
// ---------------------------------------------------------------------------
// tb_io_output_bank
//  Directed bench: dut0 without shadow, dut1 with shadow (both 8 channels,
//  page 7, channels 2/3 blank). Inputs change 1 time unit after a rising
//  edge; outputs are checked 1 time unit after the edge that acts on them.
// ---------------------------------------------------------------------------
module tb_io_output_bank;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] och0;
  logic [255:0] och1;
  int           checks   = 0;
  int           failures = 0;

  io_output_bank_if b0();
  io_output_bank_if b1();

  io_output_bank #(.NUM_CH(8), .PAGE(4'h7), .SHADOW_EN(1'b0), .BLANK_MASK(64'h0C)) dut0 (
    .i_clk(clk), .i_reset(rst), .bus(b0), .o_ch(och0));

  io_output_bank #(.NUM_CH(8), .PAGE(4'h7), .SHADOW_EN(1'b1), .BLANK_MASK(64'h0C)) dut1 (
    .i_clk(clk), .i_reset(rst), .bus(b1), .o_ch(och1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    b0.f_io_wren = 1'b0; b0.i_rd_en = 1'b0; b0.i_commit = 1'b0;
    b1.f_io_wren = 1'b0; b1.i_rd_en = 1'b0; b1.i_commit = 1'b0;
  endtask

  // One bus cycle on the selected DUT, then return 1 unit after the edge.
  task automatic op(input int sel, input logic [31:0] addr, input logic [31:0] data,
                    input logic [2:0] f3, input logic wr, input logic rd, input logic cm);
    if (sel == 0) begin
      b0.i_io_addr = addr; b0.i_st_data = data; b0.i_funct3 = f3;
      b0.f_io_wren = wr;   b0.i_rd_en   = rd;   b0.i_commit = cm;
    end else begin
      b1.i_io_addr = addr; b1.i_st_data = data; b1.i_funct3 = f3;
      b1.f_io_wren = wr;   b1.i_rd_en   = rd;   b1.i_commit = cm;
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    b0.i_io_addr = 32'h0; b0.i_st_data = 32'h0; b0.i_funct3 = 3'b010;
    b1.i_io_addr = 32'h0; b1.i_st_data = 32'h0; b1.i_funct3 = 3'b010;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_ch0",   och0[31:0],    32'h0000_0000);
    chk("rst_ch2",   och0[95:64],   32'h7F7F_7F7F);
    chk("rst_ch3",   och0[127:96],  32'h7F7F_7F7F);
    chk("rst_sh_ch3", och1[127:96], 32'h7F7F_7F7F);
    chk("rst_err",   32'(b0.o_err),      32'h0);
    chk("rst_valid", 32'(b0.o_rd_valid), 32'h0);
    chk("rst_rdata", b0.o_rd_data,       32'h0);

    // Byte / half stores
    op(0, 32'h1000_7005, 32'h0000_00AB, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("sb_ch1",  och0[63:32], 32'h0000_AB00);
    chk("sb_err",  32'(b0.o_err), 32'h0);
    op(0, 32'h1000_7006, 32'h0000_1234, 3'b001, 1'b1, 1'b0, 1'b0);
    chk("sh_ch1",  och0[63:32], 32'h1234_AB00);

    // Alias modes on ch0
    op(0, 32'h1000_7400, 32'h0000_000F, 3'b010, 1'b1, 1'b0, 1'b0);
    chk("set_ch0",    och0[31:0], 32'h0000_000F);
    op(0, 32'h1000_7800, 32'h0000_0003, 3'b010, 1'b1, 1'b0, 1'b0);
    chk("clear_ch0",  och0[31:0], 32'h0000_000C);
    op(0, 32'h1000_7C00, 32'h0000_00FF, 3'b010, 1'b1, 1'b0, 1'b0);
    chk("toggle_ch0", och0[31:0], 32'h0000_00F3);

    // CLEAR byte lane 3 of blank ch3
    op(0, 32'h1000_780F, 32'h0000_00FF, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("sb_clr_ch3", och0[127:96], 32'h007F_7F7F);

    // Dropped stores
    op(0, 32'h1000_7001, 32'h0000_FFFF, 3'b001, 1'b1, 1'b0, 1'b0);
    chk("drop_sh_err", 32'(b0.o_err), 32'h1);
    chk("drop_sh_ch0", och0[31:0], 32'h0000_00F3);
    op(0, 32'h1000_7002, 32'hFFFF_FFFF, 3'b010, 1'b1, 1'b0, 1'b0);
    chk("drop_sw_err", 32'(b0.o_err), 32'h1);
    chk("drop_sw_ch0", och0[31:0], 32'h0000_00F3);
    op(0, 32'h1000_7000, 32'hFFFF_FFFF, 3'b011, 1'b1, 1'b0, 1'b0);
    chk("drop_f3_err", 32'(b0.o_err), 32'h1);
    chk("drop_f3_ch0", och0[31:0], 32'h0000_00F3);
    op(0, 32'h1000_7020, 32'hFFFF_FFFF, 3'b010, 1'b1, 1'b0, 1'b0);
    chk("drop_idx_err", 32'(b0.o_err), 32'h1);
    chk("drop_idx_ch7", och0[255:224], 32'h0000_0000);
    op(0, 32'h1000_6000, 32'hDEAD_BEEF, 3'b010, 1'b1, 1'b0, 1'b0);
    chk("nohit_err", 32'(b0.o_err), 32'h0);
    chk("nohit_ch0", och0[31:0], 32'h0000_00F3);

    // Read-before-write on ch1, then readback
    op(0, 32'h1000_7004, 32'h0000_0099, 3'b010, 1'b1, 1'b1, 1'b0);
    chk("rbw_valid", 32'(b0.o_rd_valid), 32'h1);
    chk("rbw_data",  b0.o_rd_data, 32'h1234_AB00);
    chk("rbw_ch1",   och0[63:32], 32'h0000_0099);
    op(0, 32'h1000_7004, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0);
    chk("rd_ch1",    b0.o_rd_data, 32'h0000_0099);
    op(0, 32'h1000_7008, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0);
    chk("rd_ch2",    b0.o_rd_data, 32'h7F7F_7F7F);
    op(0, 32'h1000_7008, 32'h0, 3'b010, 1'b0, 1'b0, 1'b0);
    chk("noread_valid", 32'(b0.o_rd_valid), 32'h0);
    chk("noread_hold",  b0.o_rd_data, 32'h7F7F_7F7F);
    op(0, 32'h1000_7020, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0);
    chk("rd_idx_valid", 32'(b0.o_rd_valid), 32'h1);
    chk("rd_idx_data",  b0.o_rd_data, 32'h0);
    op(0, 32'h1000_700C, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0);
    chk("rd_ch3", b0.o_rd_data, 32'h007F_7F7F);
    op(0, 32'h1000_500C, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0);
    chk("rd_nohit_valid", 32'(b0.o_rd_valid), 32'h1);
    chk("rd_nohit_data",  b0.o_rd_data, 32'h0);

    // Shadow bank
    op(1, 32'h1000_7010, 32'h0000_0055, 3'b010, 1'b1, 1'b0, 1'b0);
    chk("sh_live_ch4", och1[159:128], 32'h0000_0000);
    op(1, 32'h1000_7010, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0);
    chk("sh_rd_ch4",   b1.o_rd_data, 32'h0000_0055);
    chk("sh_live_ch4b", och1[159:128], 32'h0000_0000);
    op(1, 32'h1000_7010, 32'h0000_0066, 3'b010, 1'b1, 1'b0, 1'b1);
    chk("commit_ch4",  och1[159:128], 32'h0000_0066);
    chk("commit_ch2",  och1[95:64], 32'h7F7F_7F7F);

    // Reset with a store in flight: store dropped, bank back to reset values
    rst = 1'b0;
    op(0, 32'h1000_7000, 32'h0000_0001, 3'b010, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_ch0", och0[31:0],   32'h0000_0000);
    chk("rst_mid_ch1", och0[63:32],  32'h0000_0000);
    chk("rst_mid_ch3", och0[127:96], 32'h7F7F_7F7F);
    chk("rst_mid_sh4", och1[159:128], 32'h0000_0000);
    chk("rst_mid_err", 32'(b0.o_err), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
